// File: rtl/bsg_round_robin_1_to_n_credited_if.sv
// Handshake bundle between a single producer stream and the credited
// 1-to-N round-robin scheduler. The slave modport is the scheduler's view,
// the master modport is the view of whatever surrounds it.
interface bsg_round_robin_1_to_n_credited_if #(
    parameter int num_out_p    = 4,
    parameter int ptr_width_lp = 2
);
    logic                    valid_i;
    logic                    ready_and_o;
    logic [num_out_p-1:0]    valid_o;
    logic [num_out_p-1:0]    ready_and_i;
    logic [num_out_p-1:0]    credit_i;
    logic [num_out_p-1:0]    active_mask_i;
    logic [ptr_width_lp-1:0] ptr_o;
    logic                    credit_overflow_o;

    modport master (
        output valid_i, ready_and_i, credit_i, active_mask_i,
        input  ready_and_o, valid_o, ptr_o, credit_overflow_o
    );

    modport slave (
        input  valid_i, ready_and_i, credit_i, active_mask_i,
        output ready_and_o, valid_o, ptr_o, credit_overflow_o
    );
endinterface

// File: rtl/bsg_round_robin_1_to_n_credited.sv
// Credit-based strict round-robin steering of one valid/ready stream onto
// num_out_p channels. A stalled or credit-starved channel blocks the
// rotation rather than being skipped, so an n-to-1 collector walking the
// same mask recovers the original order.
module bsg_round_robin_1_to_n_credited #(
    parameter  int num_out_p    = 4,
    parameter  int credits_p    = 4,
    localparam int ptr_width_lp = (num_out_p > 1) ? $clog2(num_out_p) : 1,
    localparam int cnt_width_lp = $clog2(credits_p + 1)
) (
    input logic clk_i,
    input logic reset_n_i,
    bsg_round_robin_1_to_n_credited_if.slave bus
);

    localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(credits_p);

    logic [ptr_width_lp-1:0] ptr_reg;
    logic [ptr_width_lp-1:0] ptr_next;
    logic [ptr_width_lp-1:0] eff;
    logic                    any_active;
    logic                    has_credit;
    logic                    xfer;
    logic [num_out_p-1:0]    cnt_nonzero;
    logic [num_out_p-1:0]    ovf_hit;
    logic [num_out_p-1:0]    onehot;
    logic                    overflow_reg;

    // (base + off) modulo num_out_p, valid for off in [0, num_out_p)
    function automatic logic [ptr_width_lp-1:0] wrap_idx(
        input logic [ptr_width_lp-1:0] base,
        input int                      off
    );
        int s;
        s = int'(base) + off;
        if (s >= num_out_p) s = s - num_out_p;
        return ptr_width_lp'(s);
    endfunction

    // Effective channel: first active index at or after ptr_reg (descending
    // scan so the smallest offset wins). Falls back to ptr_reg if none active.
    always_comb begin
        eff = ptr_reg;
        for (int k = num_out_p - 1; k >= 0; k--) begin
            if (bus.active_mask_i[wrap_idx(ptr_reg, k)]) eff = wrap_idx(ptr_reg, k);
        end
    end

    // Next pointer: first active index strictly after eff; with a single
    // active channel the scan finds nothing and the pointer stays on eff.
    always_comb begin
        ptr_next = eff;
        for (int k = num_out_p - 1; k >= 1; k--) begin
            if (bus.active_mask_i[wrap_idx(eff, k)]) ptr_next = wrap_idx(eff, k);
        end
    end

    assign any_active = |bus.active_mask_i;
    assign has_credit = cnt_nonzero[eff];

    // One-hot decode of the effective channel
    always_comb begin
        onehot      = '0;
        onehot[eff] = 1'b1;
    end

    // Outputs are gated by reset so the stream is cut the instant reset
    // asserts; valid_o deliberately does not look at ready_and_i.
    assign bus.valid_o     = (reset_n_i && bus.valid_i && any_active && has_credit) ? onehot : '0;
    assign bus.ready_and_o = reset_n_i & bus.ready_and_i[eff] & any_active & has_credit;
    assign bus.ptr_o       = eff;
    assign xfer            = bus.valid_i & bus.ready_and_o;

    // Pointer advances only on a completed transfer
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_reg <= '0;
        end else if (xfer) begin
            ptr_reg <= ptr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < num_out_p; gi++) begin : gen_ch
            logic [cnt_width_lp-1:0] cnt_reg;
            logic                    send;

            assign send           = xfer && (eff == ptr_width_lp'(gi));
            assign cnt_nonzero[gi] = (cnt_reg != '0);
            assign ovf_hit[gi]     = bus.credit_i[gi] & ~send & (cnt_reg == cnt_max_lp);

            // Credit counter: a send and a return in the same cycle cancel;
            // a lone return saturates at the ceiling.
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    cnt_reg <= cnt_max_lp;
                end else if (bus.credit_i[gi] && !send) begin
                    if (cnt_reg != cnt_max_lp) cnt_reg <= cnt_reg + 1'b1;
                end else if (send && !bus.credit_i[gi]) begin
                    cnt_reg <= cnt_reg - 1'b1;
                end
            end
        end
    endgenerate

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            overflow_reg <= 1'b0;
        end else if (|ovf_hit) begin
            overflow_reg <= 1'b1;
        end
    end

    assign bus.credit_overflow_o = overflow_reg;

endmodule

// File: tb/tb_bsg_round_robin_1_to_n_credited.sv
// Directed scoreboard bench for the credited 1-to-N round-robin scheduler
// (4 channels, 2 credits each).
module tb_bsg_round_robin_1_to_n_credited;

    localparam int N = 4;
    localparam int C = 2;
    localparam logic [3:0] F = 4'hF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    bsg_round_robin_1_to_n_credited_if #(.num_out_p(N), .ptr_width_lp(2)) bus ();

    bsg_round_robin_1_to_n_credited #(.num_out_p(N), .credits_p(C)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    typedef struct {
        int         id;
        logic [3:0] valid;
        logic       ready;
        logic [1:0] ptr;
        logic       ptr_chk;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;

    // Monitor: pops one expectation per cycle and compares mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (bus.valid_o !== mon_e.valid || bus.ready_and_o !== mon_e.ready ||
                (mon_e.ptr_chk && bus.ptr_o !== mon_e.ptr) ||
                bus.credit_overflow_o !== mon_e.ovf) begin
                failures++;
                $display("FAIL vec%0d valid_o=%b exp=%b ready_and_o=%b exp=%b ptr_o=%0d exp=%0d(chk=%b) ovf=%b exp=%b",
                         mon_e.id, bus.valid_o, mon_e.valid, bus.ready_and_o, mon_e.ready,
                         bus.ptr_o, mon_e.ptr, mon_e.ptr_chk, bus.credit_overflow_o, mon_e.ovf);
            end else begin
                $display("vec%0d ok valid_o=%b ready_and_o=%b ptr_o=%0d ovf=%b",
                         mon_e.id, bus.valid_o, bus.ready_and_o, bus.ptr_o, bus.credit_overflow_o);
            end
        end
    end

    task automatic drive(input logic rst, input logic v, input logic [3:0] rdy,
                         input logic [3:0] cr, input logic [3:0] mask);
        reset_n           = rst;
        bus.valid_i       = v;
        bus.ready_and_i   = rdy;
        bus.credit_i      = cr;
        bus.active_mask_i = mask;
    endtask

    task automatic expect_out(input logic [3:0] ev, input logic er, input logic [1:0] ep,
                              input logic pc, input logic eo);
        exp_t e;
        e.id = vec_id; e.valid = ev; e.ready = er; e.ptr = ep; e.ptr_chk = pc; e.ovf = eo;
        exp_q.push_back(e);
        vec_id++;
    endtask

    task automatic step(input logic rst, input logic v, input logic [3:0] rdy,
                        input logic [3:0] cr, input logic [3:0] mask,
                        input logic [3:0] ev, input logic er, input logic [1:0] ep,
                        input logic pc, input logic eo);
        @(posedge clk);
        #1;
        drive(rst, v, rdy, cr, mask);
        expect_out(ev, er, ep, pc, eo);
    endtask

    initial begin
        logic [3:0] oh;
        drive(1'b0, 1'b1, F, 4'b0000, F);

        // Reset state
        step(0, 1, F, 4'b0000, F, 4'b0000, 0, 2'd0, 1, 0);

        // Full rotation twice drains both credits of every channel
        for (int i = 0; i < 8; i++) begin
            oh = 4'b0001 << (i % 4);
            step(1, 1, F, 4'b0000, F, oh, 1, 2'(i % 4), 1, 0);
        end
        step(1, 1, F, 4'b0000, F, 4'b0000, 0, 2'd0, 1, 0);
        // Credit on channel 2 does not unblock channel 0
        step(1, 1, F, 4'b0100, F, 4'b0000, 0, 2'd0, 1, 0);
        step(1, 1, F, 4'b0001, F, 4'b0000, 0, 2'd0, 1, 0);
        step(1, 1, F, 4'b0000, F, 4'b0001, 1, 2'd0, 1, 0);

        // Mask 1010: refill channels 1 and 3, then alternate with credit returned alongside each send
        step(1, 0, F, 4'b1010, 4'b1010, 4'b0000, 0, 2'd1, 1, 0);
        step(1, 1, F, 4'b0010, 4'b1010, 4'b0010, 1, 2'd1, 1, 0);
        step(1, 1, F, 4'b1000, 4'b1010, 4'b1000, 1, 2'd3, 1, 0);
        step(1, 1, F, 4'b0010, 4'b1010, 4'b0010, 1, 2'd1, 1, 0);
        step(1, 1, F, 4'b1000, 4'b1010, 4'b1000, 1, 2'd3, 1, 0);

        // Channel 1 stalls the rotation for five cycles, then releases
        for (int i = 0; i < 5; i++)
            step(1, 1, 4'b1101, 4'b0000, F, 4'b0010, 0, 2'd1, 1, 0);
        step(1, 1, F, 4'b0000, F, 4'b0010, 1, 2'd1, 1, 0);
        step(1, 0, F, 4'b0000, F, 4'b0000, 1, 2'd2, 1, 0);

        // Credit overflow on channel 3 (1 -> 2, then one too many)
        step(1, 0, F, 4'b1000, F, 4'b0000, 1, 2'd2, 1, 0);
        step(1, 0, F, 4'b1000, F, 4'b0000, 1, 2'd2, 1, 0);
        step(1, 0, F, 4'b0000, F, 4'b0000, 1, 2'd2, 1, 1);

        // Mask changes act combinationally
        step(1, 0, F, 4'b0000, 4'b1000, 4'b0000, 1, 2'd3, 1, 1);
        step(1, 0, F, 4'b0000, 4'b0011, 4'b0000, 0, 2'd0, 1, 1);
        step(1, 1, F, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, 1);

        // Send + credit on channel 0 in the same cycle with one credit left
        step(1, 0, F, 4'b0001, F, 4'b0000, 1, 2'd2, 1, 1);
        step(1, 1, F, 4'b0001, 4'b0001, 4'b0001, 1, 2'd0, 1, 1);
        step(1, 1, F, 4'b0000, 4'b0001, 4'b0001, 1, 2'd0, 1, 1);
        step(1, 1, F, 4'b0000, 4'b0001, 4'b0000, 0, 2'd0, 1, 1);

        // Asynchronous reset mid-cycle while channel 2 is offered
        @(posedge clk);
        #1;
        drive(1, 1, F, 4'b0000, 4'b0100);
        #1;
        checks++;
        if (bus.valid_o !== 4'b0100 || bus.ready_and_o !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset valid_o=%b exp=0100 ready_and_o=%b exp=1",
                     bus.valid_o, bus.ready_and_o);
        end else begin
            $display("pre_reset ok valid_o=%b ready_and_o=%b", bus.valid_o, bus.ready_and_o);
        end
        #1;
        reset_n = 1'b0;
        expect_out(4'b0000, 0, 2'd0, 0, 0);
        step(0, 1, F, 4'b0000, F, 4'b0000, 0, 2'd0, 1, 0);

        // After release: pointer at 0 and every channel back to two credits
        for (int i = 0; i < 8; i++) begin
            oh = 4'b0001 << (i % 4);
            step(1, 1, F, 4'b0000, F, oh, 1, 2'(i % 4), 1, 0);
        end
        step(1, 1, F, 4'b0000, F, 4'b0000, 0, 2'd0, 1, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
